// File: rtl/piezo_tone_decoder.sv
// Piezo square-wave half-period meter and debounced sound-source classifier.
// Optional click counter (click_count/click_clr) enabled by `define TONE_DEC_CLICK_CNT_EN.
module piezo_tone_decoder #(
    parameter int STABLE_CNT = 2,
    parameter int TOL        = 64,
    parameter int TIMEOUT    = 400000,
    parameter int ENG_MIN    = 60001,
    parameter int ENG_MAX    = 300001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        piezo_in,
`ifdef TONE_DEC_CLICK_CNT_EN
    input  logic        click_clr,
    output logic [7:0]  click_count,
`endif
    output logic [19:0] half_period,
    output logic        meas_valid,
    output logic [2:0]  tone_class,
    output logic [3:0]  note_id,
    output logic        class_changed
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    localparam logic [2:0] CLS_SILENT  = 3'd0;
    localparam logic [2:0] CLS_HORN    = 3'd1;
    localparam logic [2:0] CLS_TICK    = 3'd2;
    localparam logic [2:0] CLS_TOCK    = 3'd3;
    localparam logic [2:0] CLS_NOTE    = 3'd4;
    localparam logic [2:0] CLS_ENGINE  = 3'd5;
    localparam logic [2:0] CLS_UNKNOWN = 3'd7;

    localparam logic [19:0] CNT_MAX    = 20'hFFFFF;
    localparam logic [19:0] TOL_W      = 20'(TOL);
    localparam logic [19:0] TIMEOUT_M1 = 20'(TIMEOUT - 1);
    localparam logic [19:0] ENG_MIN_W  = 20'(ENG_MIN);
    localparam logic [19:0] ENG_MAX_W  = 20'(ENG_MAX);
    localparam logic [3:0]  STABLE_W   = 4'(STABLE_CNT);
    localparam logic [3:0]  RUN_MAX    = 4'd15;

    localparam logic [19:0] HORN_P = 20'd62501;
    localparam logic [19:0] TICK_P = 20'd12501;
    localparam logic [19:0] TOCK_P = 20'd15626;
    localparam logic [19:0] NOTE_P [9] = '{
        20'd95555, 20'd75843, 20'd60198, 20'd56819, 20'd50620,
        20'd47779, 20'd42566, 20'd40177, 20'd37922
    };

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync2_dly_q, sync2_dly_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] stage_q, stage_d;
    logic        pend_q, pend_d;
    logic [19:0] half_period_q, half_period_d;
    logic        meas_valid_q, meas_valid_d;
    logic [2:0]  tone_class_q, tone_class_d;
    logic [3:0]  note_id_q, note_id_d;
    logic        class_changed_q, class_changed_d;
    logic [2:0]  prev_class_q, prev_class_d;
    logic [3:0]  prev_note_q, prev_note_d;
    logic [3:0]  run_q, run_d;

    logic        edge_det;
    logic [19:0] cnt_inc;
    logic [2:0]  raw_class;
    logic [3:0]  raw_note;
    logic        note_hit;

    function automatic logic in_window(input logic [19:0] d, input logic [19:0] center);
        return (d >= center - TOL_W) && (d <= center + TOL_W);
    endfunction

    // Classify the staged half-period; first match wins, lowest note index wins.
    always_comb begin
        raw_class = CLS_UNKNOWN;
        raw_note  = 4'd0;
        note_hit  = 1'b0;
        for (int k = 8; k >= 0; k--) begin
            if (in_window(stage_q, NOTE_P[k])) begin
                note_hit = 1'b1;
                raw_note = 4'(k);
            end
        end
        if (in_window(stage_q, HORN_P)) begin
            raw_class = CLS_HORN;
            raw_note  = 4'd0;
        end else if (in_window(stage_q, TICK_P)) begin
            raw_class = CLS_TICK;
            raw_note  = 4'd0;
        end else if (in_window(stage_q, TOCK_P)) begin
            raw_class = CLS_TOCK;
            raw_note  = 4'd0;
        end else if (note_hit) begin
            raw_class = CLS_NOTE;
        end else if ((stage_q >= ENG_MIN_W) && (stage_q <= ENG_MAX_W)) begin
            raw_class = CLS_ENGINE;
            raw_note  = 4'd0;
        end else begin
            raw_class = CLS_UNKNOWN;
            raw_note  = 4'd0;
        end
    end

    assign edge_det = sync2_q ^ sync2_dly_q;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 20'd1;

    // An edge captures cnt+1 into a staging register; the following cycle
    // publishes it together with the debounced class so both change at once.
    always_comb begin
        state_d         = state_q;
        sync1_d         = piezo_in;
        sync2_d         = sync1_q;
        sync2_dly_d     = sync2_q;
        cnt_d           = cnt_inc;
        stage_d         = stage_q;
        pend_d          = 1'b0;
        half_period_d   = half_period_q;
        meas_valid_d    = 1'b0;
        tone_class_d    = tone_class_q;
        note_id_d       = note_id_q;
        class_changed_d = 1'b0;
        prev_class_d    = prev_class_q;
        prev_note_d     = prev_note_q;
        run_d           = run_q;

        if (pend_q) begin
            half_period_d = stage_q;
            meas_valid_d  = 1'b1;
            prev_class_d  = raw_class;
            prev_note_d   = raw_note;
            if ((raw_class == prev_class_q) && (raw_note == prev_note_q)) begin
                run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
            end else begin
                run_d = 4'd1;
            end
            if ((run_d >= STABLE_W) &&
                ((raw_class != tone_class_q) || (raw_note != note_id_q))) begin
                tone_class_d    = raw_class;
                note_id_d       = raw_note;
                class_changed_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (edge_det) begin
                    cnt_d   = 20'd0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (edge_det) begin
                    stage_d = cnt_inc;
                    pend_d  = 1'b1;
                    cnt_d   = 20'd0;
                end else if (cnt_q == TIMEOUT_M1) begin
                    state_d         = ST_IDLE;
                    tone_class_d    = CLS_SILENT;
                    note_id_d       = 4'd0;
                    class_changed_d = (tone_class_q != CLS_SILENT);
                    run_d           = 4'd0;
                    prev_class_d    = CLS_SILENT;
                    prev_note_d     = 4'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            sync2_dly_q     <= 1'b0;
            cnt_q           <= 20'd0;
            stage_q         <= 20'd0;
            pend_q          <= 1'b0;
            half_period_q   <= 20'd0;
            meas_valid_q    <= 1'b0;
            tone_class_q    <= CLS_SILENT;
            note_id_q       <= 4'd0;
            class_changed_q <= 1'b0;
            prev_class_q    <= CLS_SILENT;
            prev_note_q     <= 4'd0;
            run_q           <= 4'd0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            sync2_dly_q     <= sync2_dly_d;
            cnt_q           <= cnt_d;
            stage_q         <= stage_d;
            pend_q          <= pend_d;
            half_period_q   <= half_period_d;
            meas_valid_q    <= meas_valid_d;
            tone_class_q    <= tone_class_d;
            note_id_q       <= note_id_d;
            class_changed_q <= class_changed_d;
            prev_class_q    <= prev_class_d;
            prev_note_q     <= prev_note_d;
            run_q           <= run_d;
        end
    end

    assign half_period   = half_period_q;
    assign meas_valid    = meas_valid_q;
    assign tone_class    = tone_class_q;
    assign note_id       = note_id_q;
    assign class_changed = class_changed_q;

`ifdef TONE_DEC_CLICK_CNT_EN
    logic [7:0] click_count_q, click_count_d;

    // Clear has priority over a same-cycle click increment.
    always_comb begin
        click_count_d = click_count_q;
        if (click_clr) begin
            click_count_d = 8'd0;
        end else if (class_changed_d &&
                     ((tone_class_d == CLS_TICK) || (tone_class_d == CLS_TOCK))) begin
            click_count_d = click_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_count_q <= 8'd0;
        end else begin
            click_count_q <= click_count_d;
        end
    end

    assign click_count = click_count_q;
`endif

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Self-checking bench for piezo_tone_decoder: directed and random half-periods
// compared against a rule-level model of measurement, classification and debounce.
module tb_piezo_tone_decoder;

   localparam int STABLE_CNT = 2;
   localparam int TOL        = 64;
   localparam int TIMEOUT    = 400000;
   localparam int ENG_MIN    = 60001;
   localparam int ENG_MAX    = 300001;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        piezoIn;
   logic [19:0] halfPeriod;
   logic        measValid;
   logic [2:0]  toneClass;
   logic [3:0]  noteId;
   logic        classChanged;
`ifdef TONE_DEC_CLICK_CNT_EN
   logic        clickClr;
   logic [7:0]  clickCount;
`endif

   piezo_tone_decoder #(
      .STABLE_CNT (STABLE_CNT),
      .TOL        (TOL),
      .TIMEOUT    (TIMEOUT),
      .ENG_MIN    (ENG_MIN),
      .ENG_MAX    (ENG_MAX)
   ) dut (
      .clk           (clock),
      .rst_n         (rst_n),
      .piezo_in      (piezoIn),
`ifdef TONE_DEC_CLICK_CNT_EN
      .click_clr     (clickClr),
      .click_count   (clickCount),
`endif
      .half_period   (halfPeriod),
      .meas_valid    (measValid),
      .tone_class    (toneClass),
      .note_id       (noteId),
      .class_changed (classChanged)
   );

   // 50 MHz clock
   always #10 clock = ~clock;

   int evaluated = 0;
   int failures  = 0;

   int notesP [9] = '{95555, 75843, 60198, 56819, 50620, 47779, 42566, 40177, 37922};

   // Reference model state
   bit measuring = 1'b0;
   int expMeas = 0;
   int expChanges = 0;
   int expHalf = 0;
   int expClass = 0;
   int expNote = 0;
   int expClicks = 0;
   int histC[$];
   int histN[$];

   // Observed pulse counts, sampled on the falling edge
   int measCount = 0;
   int changeCount = 0;
   logic prevMeas = 1'b0;
   logic prevChg = 1'b0;

   // Count output pulses and make sure neither ever lasts two cycles
   always @(negedge clock) begin
      if (measValid) begin
         measCount++;
         evaluated++;
         assert (prevMeas === 1'b0) else begin
            failures++;
            $error("[TB] FAIL meas_valid_width: observed 2 cycles expected 1");
         end
      end
      if (classChanged) begin
         changeCount++;
         evaluated++;
         assert (prevChg === 1'b0) else begin
            failures++;
            $error("[TB] FAIL class_changed_width: observed 2 cycles expected 1");
         end
      end
      prevMeas = measValid;
      prevChg  = classChanged;
   end

   function automatic int absi(input int x);
      return (x < 0) ? -x : x;
   endfunction

   function automatic int refClass(input int d);
      if (absi(d - 62501) <= TOL) return 1;
      if (absi(d - 12501) <= TOL) return 2;
      if (absi(d - 15626) <= TOL) return 3;
      for (int k = 0; k < 9; k++)
         if (absi(d - notesP[k]) <= TOL) return 4;
      if (d >= ENG_MIN && d <= ENG_MAX) return 5;
      return 7;
   endfunction

   function automatic int refNote(input int d);
      for (int k = 0; k < 9; k++)
         if (absi(d - notesP[k]) <= TOL) return k;
      return 0;
   endfunction

   // Silence after a long gap: class drops to SILENT and history is forgotten
   task automatic modelTimeout();
      measuring = 1'b0;
      if (expClass != 0) expChanges++;
      expClass = 0;
      expNote  = 0;
      histC.delete();
      histN.delete();
   endtask

   task automatic modelReset();
      measuring = 1'b0;
      expHalf   = 0;
      expClass  = 0;
      expNote   = 0;
      expClicks = 0;
      histC.delete();
      histN.delete();
   endtask

   // One toggle observed after a gap of 'half' cycles since the previous toggle
   task automatic modelEdge(input int half);
      int c;
      int n;
      int run;
      if (measuring && half > TIMEOUT) modelTimeout();
      if (!measuring) begin
         measuring = 1'b1;
         return;
      end
      expMeas++;
      expHalf = half;
      c = refClass(half);
      n = (c == 4) ? refNote(half) : 0;
      histC.push_back(c);
      histN.push_back(n);
      run = 0;
      for (int i = histC.size() - 1; i >= 0; i--) begin
         if (histC[i] == c && histN[i] == n) run++;
         else break;
      end
      if (run > 15) run = 15;
      if (run >= STABLE_CNT && (c != expClass || n != expNote)) begin
         expClass = c;
         expNote  = n;
         expChanges++;
         if (c == 2 || c == 3) expClicks = (expClicks + 1) % 256;
      end
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      evaluated++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_meas_count"}, measCount, expMeas);
      checkOutput({tag, "_half_period"}, int'(halfPeriod), expHalf);
      checkOutput({tag, "_tone_class"}, int'(toneClass), expClass);
      checkOutput({tag, "_note_id"}, int'(noteId), expNote);
      checkOutput({tag, "_change_count"}, changeCount, expChanges);
`ifdef TONE_DEC_CLICK_CNT_EN
      checkOutput({tag, "_click_count"}, int'(clickCount), expClicks);
`endif
   endtask

   // Toggle piezo_in exactly 'half' cycles after the previous toggle, then check
   task automatic applyStimulus(input int half, input string tag);
      repeat (half - 6) @(posedge clock);
      #1 piezoIn = ~piezoIn;
      modelEdge(half);
      repeat (6) @(posedge clock);
      #1;
      checkAll(tag);
   endtask

   task automatic idleWait(input int n, input string tag);
      repeat (n) @(posedge clock);
      #1;
      if (measuring && n > TIMEOUT) modelTimeout();
      checkAll(tag);
   endtask

   initial begin
      int half;
      int base;
      int off;

      rst_n   = 1'b1;
      piezoIn = 1'b0;
`ifdef TONE_DEC_CLICK_CNT_EN
      clickClr = 1'b0;
`endif
      #1 rst_n = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      checkAll("reset");
      @(negedge clock);
      rst_n = 1'b1;

      // Long silence from reset: no pulses, class stays SILENT
      idleWait(420000, "quiet");

      // Horn: five toggles at 62501
      for (int i = 0; i < 5; i++) applyStimulus(62501, "horn");

      // Asynchronous reset in the middle of a horn period
      repeat (20000) @(posedge clock);
      #3 rst_n = 1'b0;
      piezoIn = 1'b0;
      modelReset();
      #1;
      checkAll("async_reset");
      repeat (10) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      applyStimulus(30000, "post_reset_first_edge");

      // Turn-signal ticks, then silence by timeout
      for (int i = 0; i < 12; i++) applyStimulus(12501, "tick");
      idleWait(TIMEOUT + 20, "tick_timeout");

      // Reverse-melody notes: E5 then DS5
      applyStimulus(20000, "note_start");
      applyStimulus(37922, "note_e5");
      applyStimulus(37922, "note_e5");
      applyStimulus(40177, "note_ds5");
      applyStimulus(40177, "note_ds5");

      // Engine, above-range unknown, and just below the GS4 window
      applyStimulus(150000, "engine");
      applyStimulus(150000, "engine");
      applyStimulus(300002, "unknown");
      applyStimulus(300002, "unknown");
      applyStimulus(60000 + TOL + 1, "engine_low");
      applyStimulus(60000 + TOL + 1, "engine_low");
      applyStimulus(12501 + TOL, "tick_edge_in");
      applyStimulus(12501 + TOL + 1, "tick_edge_out");

      // Edge exactly at the timeout threshold still measures; one later times out
      applyStimulus(TIMEOUT, "timeout_edge");
      applyStimulus(TIMEOUT + 1, "timeout_over");

      // Random half-periods around the class centres and window edges
      half = 12501;
      for (int i = 0; i < 20; i++) begin
         if (i == 0 || $urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 5))
               0: base = 12501;
               1: base = 15626;
               2: base = 62501;
               3: base = notesP[$urandom_range(0, 8)];
               4: base = int'($urandom_range(2000, 9000));
               default: base = int'($urandom_range(61000, 90000));
            endcase
            off  = int'($urandom_range(0, 2 * TOL + 4)) - (TOL + 2);
            half = base + off;
         end
         applyStimulus(half, "random");
      end

`ifdef TONE_DEC_CLICK_CNT_EN
      @(negedge clock);
      clickClr = 1'b1;
      @(negedge clock);
      clickClr = 1'b0;
      expClicks = 0;
      #1;
      checkOutput("click_clear", int'(clickCount), expClicks);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule

// File: doc/piezo_tone_decoder.md
Name: piezo_tone_decoder

Overview:
- Receive-side checker for the piezo square-wave output of the sound unit. Used in self-test, and as a bench monitor, on the same 50 MHz clock.
- Measures the toggle-to-toggle half-period of `piezo_in` and classifies the audible source: silence, horn, turn-signal tick/tock, reverse-melody note (with note index), engine, or unknown.
- Reports a debounced class with a change pulse. A sound ECU or logic analyser core consumes it.

Parameters:
- `STABLE_CNT`, 2: consecutive identical raw classifications required before `tone_class` updates (1..15).
- `TOL`, 64: ± clk tolerance for the horn, click and note matches.
- `TIMEOUT`, 400000: clk cycles without an edge before the output is declared silent. Must be > 300001 and < 2^20.
- `ENG_MIN`, 60001: minimum engine half-period, inclusive.
- `ENG_MAX`, 300001: maximum engine half-period, inclusive.

Ports:
- `clk` input 1: 50 MHz system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `piezo_in` input 1: piezo square wave. Passed through a 2-flop synchroniser internally.
- `half_period` output 20: last measured half-period in clk cycles. Reset value 0.
- `meas_valid` output 1: one-cycle pulse when `half_period` updates. Reset value 0.
- `tone_class` output 3: debounced class, encoded 0 SILENT, 1 HORN, 2 TICK, 3 TOCK, 4 NOTE, 5 ENGINE, 7 UNKNOWN. Reset value 0.
- `note_id` output 4: valid when `tone_class`=NOTE, encoded 0 C4, 1 E4, 2 GS4, 3 A4, 4 B4, 5 C5, 6 D5, 7 DS5, 8 E5. Reset value 0.
- `class_changed` output 1: one-cycle pulse whenever `tone_class` or `note_id` changes value. Reset value 0.

Behaviour:
- Synchroniser and edge detection:
  - `piezo_in` → `sync1` → `sync2`; edge = `sync2` ≠ `sync2_d`. Both rising and falling edges count.
  - `meas_valid` rises 3 clk after the clk edge that first samples the new `piezo_in` level.
- Measurement counter:
  - 20-bit `cnt` increments every cycle and saturates at 2^20−1.
  - On an edge, `half_period` ≤ `cnt`+1, then `cnt` resets to 0.
  - A wave toggling every N clk measures exactly N.
- FSM state IDLE (reset state, and after a timeout):
  - The first edge does not produce a measurement and does not pulse `meas_valid`.
  - It clears `cnt`, then the FSM moves to MEASURE.
- FSM state MEASURE:
  - Each edge latches `half_period`, pulses `meas_valid` and produces a raw classification.
  - When `cnt` reaches `TIMEOUT`-1 with no edge, the FSM moves to IDLE.
- Raw classification, first match wins; `d` = `half_period`:
  1. HORN if |d−62501| ≤ `TOL`.
  2. TICK if |d−12501| ≤ `TOL`.
  3. TOCK if |d−15626| ≤ `TOL`.
  4. NOTE if |d−Pk| ≤ `TOL` for note k, where Pk = 95555, 75843, 60198, 56819, 50620, 47779, 42566, 40177, 37922 for k = 0..8. Lowest k wins.
  5. ENGINE if `ENG_MIN` ≤ d ≤ `ENG_MAX`.
  6. Otherwise UNKNOWN.
  - An engine pitch that lands on a note or horn period is reported as NOTE or HORN. This is by design.
- Debounce:
  - Keep the raw class and note of the previous measurement, plus a 4-bit `run` counter.
  - If the raw result equals the previous raw result, `run` increments, saturating at 15. Otherwise `run`=1.
  - When `run` ≥ `STABLE_CNT` and the raw result differs from the outputs, update `tone_class`/`note_id` and pulse `class_changed`. This happens in the same cycle as `meas_valid`.
- Timeout:
  - On entering IDLE by timeout, `tone_class` ≤ SILENT and `note_id` ≤ 0.
  - Pulse `class_changed` only if the class was not already SILENT.
  - `run` and the raw history are cleared; `half_period` holds its last value.
- Simultaneous events: an edge in the same cycle as the timeout threshold counts as an edge, and no timeout occurs.
- Reset: `rst_n` low mid-measurement asynchronously clears all state, including the synchroniser, to the reset values.
- `class_changed` and `meas_valid` are never asserted for more than 1 cycle.

Optional Feature:
- Macro `TONE_DEC_CLICK_CNT_EN`.
- Defined:
  - Adds output `click_count` 8 bits, reset value 0.
  - It increments once per `class_changed` into TICK or TOCK and wraps from 255 to 0.
  - Adds input `click_clr`, 1 bit; a high level clears `click_count` synchronously. If the clear and an increment fall in the same cycle, the clear wins.
- Undefined: neither port exists, and the logic is absent.

Test Plan:
- Reset, `piezo_in` held 0 for 1M clk → `tone_class`=0, `meas_valid` never pulses, `class_changed` never pulses.
- Square wave toggling every 62501 clk, 5 toggles → first `meas_valid` on the 2nd toggle with `half_period`=62501. `tone_class`=HORN with a single `class_changed` pulse after the 3rd toggle (`STABLE_CNT`=2).
- Toggle every 12501 clk for 12 toggles, then stop → TICK, then after 400000 idle clk `tone_class`=SILENT with one `class_changed` pulse. With the macro defined, `click_count`=1.
- Half-period sequence 37922, 37922, 40177, 40177 → NOTE with `note_id`=8, then `note_id`=7. Two `class_changed` pulses; `tone_class` stays 4.
- Half-period 150000 repeated → ENGINE. Then 300002 repeated → UNKNOWN. Then 60000+`TOL`+1 ≈ 60065 → ENGINE (not NOTE GS4).
- Assert `rst_n` low mid-period during HORN → all outputs 0 asynchronously. After release, the first edge gives no `meas_valid`.
